seq_alu_core: RTL and testbench

//  Parametrised, clocked successor to the 8-bit bit-slice ALU/multiplier datapath.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/seq_mul_unit.sv | 68 ++++++
 rtl/seq_alu_core.sv | 169 ++++++++++++++++
 tb/tb_seq_alu_core.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode values and handshake FSM states for the sequential ALU core.
package alu_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_ADD  = 3'd0;
   localparam op_t OP_SUB  = 3'd1;
   localparam op_t OP_AND  = 3'd2;
   localparam op_t OP_OR   = 3'd3;
   localparam op_t OP_XOR  = 3'd4;
   localparam op_t OP_MULU = 3'd5;
   localparam op_t OP_MULS = 3'd6;
   localparam op_t OP_ILL  = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_mul_op(input op_t op_code);
      return (op_code == OP_MULU) || (op_code == OP_MULS);
   endfunction

endpackage

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier, one multiplier bit per cycle over a fixed WIDTH-cycle window.
// Signed mode multiplies magnitudes and negates the final product when the operand signs differ.
module seq_mul_unit #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   mcand_reg;
   logic [2*WIDTH-1:0] p_reg;
   logic [CW-1:0]      count_reg;
   logic               busy_reg;
   logic               neg_reg;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] p_next;

   // The magnitude of the most negative value still fits WIDTH bits when read as unsigned.
   always_comb begin
      a_mag = (is_signed && a[WIDTH-1]) ? (-a) : a;
      b_mag = (is_signed && b[WIDTH-1]) ? (-b) : b;
   end

   // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
   always_comb begin
      sum     = {1'b0, p_reg[2*WIDTH-1:WIDTH]}
              + (p_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
      p_next  = {sum, p_reg[WIDTH-1:1]};
      product = neg_reg ? (-p_next) : p_next;
      done    = busy_reg && (count_reg == CW'(WIDTH - 1));
      busy    = busy_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_reg <= '0;
         p_reg     <= '0;
         count_reg <= '0;
         busy_reg  <= 1'b0;
         neg_reg   <= 1'b0;
      end else if (start && !busy_reg) begin
         mcand_reg <= a_mag;
         p_reg     <= {{WIDTH{1'b0}}, b_mag};
         count_reg <= '0;
         busy_reg  <= 1'b1;
         neg_reg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (busy_reg) begin
         p_reg     <= p_next;
         count_reg <= count_reg + CW'(1);
         if (done) begin
            busy_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_alu_core.sv
// Clocked ALU with valid/ready handshakes: one-cycle logic/add/sub ops and iterative multiply,
// results and C/V/N/Z/err flags held in output registers until consumed.
module seq_alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 carry,
   output logic                 overflow,
   output logic                 negative,
   output logic                 zero,
   output logic                 err
);

   state_t             state_reg;
   logic               in_ready_reg;
   logic               out_valid_reg;
   logic [2*WIDTH-1:0] result_reg;
   logic               carry_reg;
   logic               overflow_reg;
   logic               negative_reg;
   logic               zero_reg;
   logic               err_reg;
   logic               mul_signed_reg;

   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH-1:0]   alu_lo;
   logic               alu_c;
   logic               alu_v;

   logic               mul_start;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH:0]     mul_top;
   logic               mul_v;

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign carry     = carry_reg;
   assign overflow  = overflow_reg;
   assign negative  = negative_reg;
   assign zero      = zero_reg;
   assign err       = err_reg;

   // SUB reuses the adder as a + ~b + cin, so carry out means "no borrow".
   always_comb begin
      b_eff   = (op == OP_SUB) ? ~b : b;
      sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      alu_lo  = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            alu_lo = sum_ext[WIDTH-1:0];
            alu_c  = sum_ext[WIDTH];
            alu_v  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_lo = a & b;
         OP_OR:   alu_lo = a | b;
         OP_XOR:  alu_lo = a ^ b;
         default: alu_lo = '0;
      endcase
   end

   // A signed product fits WIDTH bits only if its top WIDTH+1 bits are pure sign extension.
   always_comb begin
      mul_top = mul_product[2*WIDTH-1:WIDTH-1];
      if (mul_signed_reg) begin
         mul_v = !((&mul_top) || !(|mul_top));
      end else begin
         mul_v = |mul_product[2*WIDTH-1:WIDTH];
      end
   end

   assign mul_start = in_valid && in_ready_reg && is_mul_op(op);

   seq_mul_unit #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start     (mul_start),
      .is_signed (op == OP_MULS),
      .a         (a),
      .b         (b),
      .busy      (mul_busy),
      .done      (mul_done),
      .product   (mul_product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         in_ready_reg   <= 1'b1;
         out_valid_reg  <= 1'b0;
         result_reg     <= '0;
         carry_reg      <= 1'b0;
         overflow_reg   <= 1'b0;
         negative_reg   <= 1'b0;
         zero_reg       <= 1'b0;
         err_reg        <= 1'b0;
         mul_signed_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  in_ready_reg   <= 1'b0;
                  mul_signed_reg <= (op == OP_MULS);
                  if (is_mul_op(op)) begin
                     state_reg <= MUL;
                  end else begin
                     state_reg     <= DONE;
                     out_valid_reg <= 1'b1;
                     result_reg    <= {{WIDTH{1'b0}}, alu_lo};
                     carry_reg     <= alu_c;
                     overflow_reg  <= alu_v;
                     negative_reg  <= alu_lo[WIDTH-1];
                     zero_reg      <= (alu_lo == '0);
                     err_reg       <= (op == OP_ILL);
                  end
               end
            end
            MUL: begin
               if (mul_done) begin
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
                  result_reg    <= mul_product;
                  carry_reg     <= 1'b0;
                  overflow_reg  <= mul_v;
                  negative_reg  <= mul_product[2*WIDTH-1];
                  zero_reg      <= (mul_product == '0);
                  err_reg       <= 1'b0;
               end else if (!mul_busy) begin
                  // Multiplier idle without a completion: recover rather than wait forever.
                  state_reg    <= IDLE;
                  in_ready_reg <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu_core.sv
// Self-checking bench for seq_alu_core (WIDTH=8): directed vector table, multi-cycle corner
// sequences, and randomized transactions against an arithmetic reference model.
module tb_seq_alu_core;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          out_valid;
   logic          out_ready;
   logic [2*W-1:0] result;
   logic          carry;
   logic          overflow;
   logic          negative;
   logic          zero;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic        cin;
      logic [15:0] res;
      logic [4:0]  flg;   // {C, V, N, Z, err}
   } vec_t;

   always #5 clk = ~clk;

   seq_alu_core #(
      .WIDTH(W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .overflow  (overflow),
      .negative  (negative),
      .zero      (zero),
      .err       (err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input logic [2:0] m_op, input logic [7:0] m_a, input logic [7:0] m_b,
                                 input logic m_cin, output logic [15:0] r, output logic [4:0] f);
      int ua, ub, sa, sb, u, s;
      logic c, v, n;
      ua = int'(m_a);
      ub = int'(m_b);
      sa = int'($signed(m_a));
      sb = int'($signed(m_b));
      c = 1'b0;
      v = 1'b0;
      u = 0;
      s = 0;
      case (m_op)
         3'd0: begin
            u = ua + ub + int'(m_cin);
            s = sa + sb + int'(m_cin);
            r = 16'(u % 256);
            c = (u > 255);
            v = (s > 127) || (s < -128);
         end
         3'd1: begin
            u = ua + (255 - ub) + int'(m_cin);
            s = sa - sb - 1 + int'(m_cin);
            r = 16'(u % 256);
            c = (u > 255);
            v = (s > 127) || (s < -128);
         end
         3'd2: r = {8'h00, m_a & m_b};
         3'd3: r = {8'h00, m_a | m_b};
         3'd4: r = {8'h00, m_a ^ m_b};
         3'd5: begin
            u = ua * ub;
            r = 16'(u);
            v = (u > 255);
         end
         3'd6: begin
            s = sa * sb;
            r = 16'(s);
            v = (s > 127) || (s < -128);
         end
         default: r = 16'h0000;
      endcase
      n = (m_op == 3'd5 || m_op == 3'd6) ? r[15] : r[7];
      f = {c, v, n, (r == 16'h0000), (m_op == 3'd7)};
   endfunction

   // One full transaction; ok clears on any handshake or hold-stability violation.
   task automatic txn(input logic [2:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                      input logic t_cin, input int hold, output logic [15:0] r,
                      output logic [4:0] f, output int lat, output logic ok);
      ok       = in_ready;
      op       = t_op;
      a        = t_a;
      b        = t_b;
      cin      = t_cin;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      cin      = 1'($urandom);
      lat      = 1;
      while (!out_valid && lat < 40) begin
         if (in_ready) ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (in_ready) ok = 1'b0;
      r = result;
      f = {carry, overflow, negative, zero, err};
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         if (result !== r || {carry, overflow, negative, zero, err} !== f || !out_valid || in_ready)
            ok = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      if (out_valid || !in_ready) ok = 1'b0;
      $display("txn op=%0d a=%02h b=%02h cin=%0d result=%04h cvnze=%05b lat=%0d",
               t_op, t_a, t_b, t_cin, r, f, lat);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [13];
      logic [15:0] r, mr, r0;
      logic [4:0]  f, mf, f0;
      int          lat;
      logic        ok, stable, quiet;
      logic [2:0]  rop;
      logic [7:0]  ra, rb;
      logic        rc;

      vecs[0]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 16'h0080, 5'b01100};
      vecs[1]  = '{3'd1, 8'h00, 8'h01, 1'b1, 16'h00FF, 5'b00100};
      vecs[2]  = '{3'd1, 8'h05, 8'h05, 1'b1, 16'h0000, 5'b10010};
      vecs[3]  = '{3'd5, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 5'b01100};
      vecs[4]  = '{3'd6, 8'hFF, 8'hFF, 1'b0, 16'h0001, 5'b00000};
      vecs[5]  = '{3'd6, 8'h80, 8'h80, 1'b0, 16'h4000, 5'b01000};
      vecs[6]  = '{3'd6, 8'h80, 8'h01, 1'b0, 16'hFF80, 5'b00100};
      vecs[7]  = '{3'd7, 8'h12, 8'h34, 1'b1, 16'h0000, 5'b00011};
      vecs[8]  = '{3'd2, 8'hF0, 8'h3C, 1'b1, 16'h0030, 5'b00000};
      vecs[9]  = '{3'd3, 8'hF0, 8'h3C, 1'b0, 16'h00FC, 5'b00100};
      vecs[10] = '{3'd4, 8'hF0, 8'h3C, 1'b0, 16'h00CC, 5'b00100};
      vecs[11] = '{3'd0, 8'hFF, 8'h01, 1'b1, 16'h0001, 5'b10000};
      vecs[12] = '{3'd5, 8'h00, 8'h55, 1'b0, 16'h0000, 5'b00010};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 3'd0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_flags", 32'({carry, overflow, negative, zero, err}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) begin
         txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 0, r, f, lat, ok);
         chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
         chk($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].flg));
         chk($sformatf("vec%0d_latency", i), 32'(lat),
             (vecs[i].op == 3'd5 || vecs[i].op == 3'd6) ? 32'd9 : 32'd1);
         chk($sformatf("vec%0d_handshake", i), 32'(ok), 32'd1);
      end

      // DONE held 5 cycles with new operands offered: nothing may change or be accepted.
      op       = 3'd0;
      a        = 8'h12;
      b        = 8'h34;
      cin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      op = 3'd4;
      a  = 8'hAA;
      b  = 8'h55;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      r0     = result;
      f0     = {carry, overflow, negative, zero, err};
      stable = 1'b1;
      for (int h = 0; h < 5; h++) begin
         @(posedge clk);
         #1;
         if (result !== r0 || {carry, overflow, negative, zero, err} !== f0 || in_ready || !out_valid)
            stable = 1'b0;
      end
      chk("hold_result", 32'(r0), 32'h0046);
      chk("hold_stable", 32'(stable), 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("hold_release", 32'({out_valid, in_ready}), 32'b01);
      $display("txn hold-sequence result=%04h stable=%0d", r0, stable);

      // Reset during the 4th multiply cycle discards the operation.
      op       = 3'd5;
      a        = 8'hFF;
      b        = 8'hFF;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midmul_rst_out_valid", 32'(out_valid), 32'd0);
      chk("midmul_rst_in_ready", 32'(in_ready), 32'd1);
      chk("midmul_rst_result", 32'(result), 32'd0);
      quiet = 1'b1;
      for (int h = 0; h < 12; h++) begin
         @(posedge clk);
         #1;
         if (out_valid || !in_ready) quiet = 1'b0;
      end
      chk("midmul_rst_no_pulse", 32'(quiet), 32'd1);
      $display("txn midmul-reset quiet=%0d", quiet);
      txn(3'd6, 8'h80, 8'h80, 1'b0, 0, r, f, lat, ok);
      chk("post_rst_muls", 32'({r, f}), 32'({16'h4000, 5'b01000}));

      // Randomized traffic against the reference model.
      for (int i = 0; i < 300; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rc  = 1'($urandom);
         if (i % 10 == 0) ra = (i % 20 == 0) ? 8'h80 : 8'hFF;
         model(rop, ra, rb, rc, mr, mf);
         txn(rop, ra, rb, rc, $urandom_range(0, 2), r, f, lat, ok);
         chk($sformatf("rnd%0d_result", i), 32'(r), 32'(mr));
         chk($sformatf("rnd%0d_flags", i), 32'(f), 32'(mf));
         chk($sformatf("rnd%0d_latency", i), 32'(lat),
             (rop == 3'd5 || rop == 3'd6) ? 32'd9 : 32'd1);
         chk($sformatf("rnd%0d_handshake", i), 32'(ok), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
